// File: rtl/synth_osc_pkg.sv
// Shared types and constants for the oscillator waveform shaper: waveform
// selector, register map and per-oscillator register record.
package synth_osc_pkg;

    localparam int VOICES     = 8;
    localparam int V_OSC      = 4;
    localparam int V_WIDTH    = 3;
    localparam int O_WIDTH    = 2;
    localparam int OE_WIDTH   = 1;
    localparam int E_WIDTH    = O_WIDTH + OE_WIDTH;
    localparam int PHASE_W    = 11;
    localparam int OUT_W      = 17;
    localparam int OX_DLY     = V_OSC * VOICES - 1;
    localparam int LUT_LAT    = 1;

    localparam logic [6:0] ADR_BASE   = 7'd6;
    localparam int         ADR_STRIDE = 16;
    localparam int         REG_OFFS   = 0;
    localparam int         REG_WAVE   = 1;
    localparam int         REG_PW     = 2;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_SAW  = 2'd1,
        WAVE_SQR  = 2'd2,
        WAVE_TRI  = 2'd3
    } wave_t;

    typedef struct packed {
        logic [7:0] offs;
        wave_t      wave;
        logic [7:0] pw;
    } osc_regs_t;

    localparam osc_regs_t REGS_DEFAULT = '{offs: 8'h00, wave: WAVE_SINE, pw: 8'h80};

    function automatic logic [6:0] reg_addr(input int osc, input int k);
        return ADR_BASE + 7'(osc * ADR_STRIDE + k);
    endfunction

endpackage

// File: rtl/osc_regbank.sv
// Per-oscillator sysex registers: host-visible shadow bank plus the active
// bank that the datapath uses, refreshed only at frame start.
module osc_regbank
    import synth_osc_pkg::*;
(
    input  logic               sCLK_XVXOSC,
    input  logic               iRST_N,
    input  logic [6:0]         adr,
    input  logic [7:0]         wdata,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               osc_sel,
    output logic [7:0]         rdata,
    output logic               rvalid,
    input  logic               commit,
    input  logic [O_WIDTH-1:0] sel_osc,
    output osc_regs_t          sel_regs
);

    osc_regs_t          shadow [V_OSC];
    osc_regs_t          active [V_OSC];
    logic               hit;
    logic [O_WIDTH-1:0] hit_osc;
    logic [1:0]         hit_reg;
    logic [7:0]         rd_word;

    always_comb begin
        hit     = 1'b0;
        hit_osc = '0;
        hit_reg = '0;
        for (int o = 0; o < V_OSC; o++) begin
            for (int k = 0; k < 3; k++) begin
                if (adr == reg_addr(o, k)) begin
                    hit     = 1'b1;
                    hit_osc = O_WIDTH'(o);
                    hit_reg = 2'(k);
                end
            end
        end
    end

    always_comb begin
        rd_word = 8'h00;
        if (hit) begin
            case (hit_reg)
                2'(REG_OFFS): rd_word = shadow[hit_osc].offs;
                2'(REG_WAVE): rd_word = {6'b0, shadow[hit_osc].wave};
                2'(REG_PW):   rd_word = shadow[hit_osc].pw;
                default:      rd_word = 8'h00;
            endcase
        end
    end

    // The slot that triggers a commit must already see the freshly committed values.
    assign sel_regs = commit ? shadow[sel_osc] : active[sel_osc];

    always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int o = 0; o < V_OSC; o++) begin
                shadow[o] <= REGS_DEFAULT;
                active[o] <= REGS_DEFAULT;
            end
            rdata  <= 8'h00;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en & osc_sel;
            if (rd_en & osc_sel)
                rdata <= rd_word;
            if (commit)
                active <= shadow;
            if (wr_en & osc_sel & hit) begin
                case (hit_reg)
                    2'(REG_OFFS): shadow[hit_osc].offs <= wdata;
                    2'(REG_WAVE): shadow[hit_osc].wave <= wave_t'(wdata[1:0]);
                    2'(REG_PW):   shadow[hit_osc].pw   <= wdata;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sine_lookup.sv
// Sine table with one cycle of read latency: parabolic half-wave, mirrored
// negative for the upper half of the phase circle.
module sine_lookup (
    input  logic               clk,
    input  logic [10:0]        addr,
    output logic signed [16:0] dout
);

    logic [9:0]  x;
    logic [19:0] prod;
    logic [19:0] mag;
    logic [15:0] mag_sat;

    assign x       = addr[9:0];
    assign prod    = {10'b0, x} * (20'd1024 - {10'b0, x});
    assign mag     = prod >> 2;
    assign mag_sat = (mag > 20'd65535) ? 16'hFFFF : mag[15:0];

    always_ff @(posedge clk) begin
        dout <= addr[10] ? -$signed({1'b0, mag_sat}) : $signed({1'b0, mag_sat});
    end

endmodule

// File: rtl/osc_wave_multi.sv
// Waveform shaper: offsets/modulates the NCO phase and produces sine, saw,
// square or triangle samples with a fixed two-cycle latency.
module osc_wave_multi
    import synth_osc_pkg::*;
(
    input  logic                              sCLK_XVXOSC,
    input  logic                              iRST_N,
    input  logic [6:0]                        adr,
    input  logic [7:0]                        wdata,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic                              osc_sel,
    output logic [7:0]                        rdata,
    output logic                              rvalid,
    input  logic [V_WIDTH+E_WIDTH-1:0]        xxxx,
    input  logic                              in_valid,
    input  logic [PHASE_W-1:0]                phase_acc,
    input  logic [PHASE_W-1:0]                modulation,
    output logic signed [OUT_W-1:0]           osc_out,
    output logic                              out_valid
);

    localparam logic signed [OUT_W-1:0] SQR_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SQR_LO = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

    logic [O_WIDTH-1:0]      ox;
    logic [O_WIDTH-1:0]      ox_dly;
    logic                    commit;
    osc_regs_t               cur;
    logic [PHASE_W-1:0]      idx;
    logic [9:0]              tri_t;
    logic signed [OUT_W-1:0] shape;
    logic signed [OUT_W-1:0] shape_q;
    logic signed [OUT_W-1:0] sine_q;
    wave_t                   wave_q;
    logic                    valid_q;

    assign ox     = xxxx[E_WIDTH-1:OE_WIDTH];
    assign commit = in_valid && (xxxx == '0);

    // The bank is selected by the oscillator index the NCO saw OX_DLY slots ago.
    if (OX_DLY == 0) begin : g_no_dly
        assign ox_dly = ox;
    end else begin : g_dly
        logic [O_WIDTH-1:0] ox_line [OX_DLY];
        always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
            if (!iRST_N) begin
                for (int i = 0; i < OX_DLY; i++)
                    ox_line[i] <= '0;
            end else begin
                ox_line[0] <= ox;
                for (int i = 1; i < OX_DLY; i++)
                    ox_line[i] <= ox_line[i-1];
            end
        end
        assign ox_dly = ox_line[OX_DLY-1];
    end

    osc_regbank u_regbank (
        .sCLK_XVXOSC (sCLK_XVXOSC),
        .iRST_N      (iRST_N),
        .adr         (adr),
        .wdata       (wdata),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .osc_sel     (osc_sel),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .commit      (commit),
        .sel_osc     (ox_dly),
        .sel_regs    (cur)
    );

    assign idx   = phase_acc + modulation + {cur.offs, 3'b000};
    assign tri_t = idx[10] ? ~idx[9:0] : idx[9:0];

    always_comb begin
        shape = '0;
        case (cur.wave)
            WAVE_SAW: shape = {~idx[10], idx[9:0], 6'b0};
            WAVE_SQR: shape = (idx < {cur.pw, 3'b000}) ? SQR_HI : SQR_LO;
            WAVE_TRI: shape = {~tri_t[9], tri_t[8:0], 7'b0};
            default:  shape = '0;
        endcase
    end

    sine_lookup u_sine (
        .clk  (sCLK_XVXOSC),
        .addr (idx),
        .dout (sine_q)
    );

    // Computed shapes wait one stage alongside the table read, then merge.
    always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
        if (!iRST_N) begin
            shape_q   <= '0;
            wave_q    <= WAVE_SINE;
            valid_q   <= 1'b0;
            osc_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            shape_q   <= shape;
            wave_q    <= cur.wave;
            valid_q   <= in_valid;
            out_valid <= valid_q;
            if (valid_q)
                osc_out <= (wave_q == WAVE_SINE) ? sine_q : shape_q;
        end
    end

endmodule

// File: tb/tb_osc_wave_multi.sv
// Scoreboard bench for osc_wave_multi: a reference model predicts each sample
// and register read, the monitor compares when the DUT presents output.
module tb_osc_wave_multi;

    typedef struct packed {
        logic [7:0] offs;
        logic [1:0] wave;
        logic [7:0] pw;
    } mregs_t;

    typedef struct {
        int                 due;
        logic signed [16:0] val;
    } exp_t;

    logic               sCLK_XVXOSC = 1'b0;
    logic               iRST_N;
    logic [6:0]         adr;
    logic [7:0]         wdata;
    logic               wr_en;
    logic               rd_en;
    logic               osc_sel;
    logic [7:0]         rdata;
    logic               rvalid;
    logic [5:0]         xxxx;
    logic               in_valid;
    logic [10:0]        phase_acc;
    logic [10:0]        modulation;
    logic signed [16:0] osc_out;
    logic               out_valid;

    int                 vectors = 0;
    int                 errors  = 0;
    int                 cyc     = 0;
    exp_t               sb[$];
    logic [1:0]         oxq[$];
    mregs_t             sh[4];
    mregs_t             ac[4];
    logic signed [16:0] last_out = '0;

    osc_wave_multi dut (
        .sCLK_XVXOSC (sCLK_XVXOSC),
        .iRST_N      (iRST_N),
        .adr         (adr),
        .wdata       (wdata),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .osc_sel     (osc_sel),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .xxxx        (xxxx),
        .in_valid    (in_valid),
        .phase_acc   (phase_acc),
        .modulation  (modulation),
        .osc_out     (osc_out),
        .out_valid   (out_valid)
    );

    always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int sine_ref(input logic [10:0] i);
        int x, m;
        x = int'(i[9:0]);
        m = (x * (1024 - x)) / 4;
        if (m > 65535) m = 65535;
        return i[10] ? -m : m;
    endfunction

    function automatic int wave_ref(input logic [10:0] i, input logic [1:0] w, input logic [7:0] pw);
        int t;
        case (w)
            2'd0: return sine_ref(i);
            2'd1: return (int'(i[9:0]) - (i[10] ? 0 : 1024)) * 64;
            2'd2: return (int'(i) < int'(pw) * 8) ? 65535 : -65535;
            default: begin
                t = i[10] ? 1023 - int'(i[9:0]) : int'(i[9:0]);
                return (2 * t - 1024) * 64;
            end
        endcase
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int o = 0; o < 4; o++) begin
            if (a == 7'(6 + 16 * o)) r = sh[o].offs;
            if (a == 7'(7 + 16 * o)) r = {6'b0, sh[o].wave};
            if (a == 7'(8 + 16 * o)) r = sh[o].pw;
        end
        return r;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        for (int o = 0; o < 4; o++) begin
            if (a == 7'(6 + 16 * o)) sh[o].offs = d;
            if (a == 7'(7 + 16 * o)) sh[o].wave = d[1:0];
            if (a == 7'(8 + 16 * o)) sh[o].pw   = d;
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            sh[o] = '{offs: 8'h00, wave: 2'd0, pw: 8'h80};
            ac[o] = sh[o];
        end
        oxq.delete();
        for (int i = 0; i < 31; i++) oxq.push_back(2'd0);
        sb.delete();
        last_out = '0;
    endtask

    // One slot: drive inputs, predict, advance one clock, check register reads.
    task automatic applyStimulus(input logic v, input logic [5:0] x, input logic [10:0] ph,
                                 input logic [10:0] md, input logic w, input logic r,
                                 input logic [6:0] a, input logic [7:0] d);
        logic       cm;
        logic [7:0] rexp;
        mregs_t     p;
        logic [10:0] i;
        in_valid = v; xxxx = x; phase_acc = ph; modulation = md;
        wr_en = w; rd_en = r; osc_sel = w | r; adr = a; wdata = d;
        cm   = v && (x == 6'd0);
        rexp = model_read(a);
        if (v) begin
            p = cm ? sh[oxq[0]] : ac[oxq[0]];
            i = ph + md + {p.offs, 3'b000};
            sb.push_back('{cyc + 2, 17'(wave_ref(i, p.wave, p.pw))});
        end
        @(posedge sCLK_XVXOSC);
        cyc++;
        if (cm) for (int o = 0; o < 4; o++) ac[o] = sh[o];
        if (w) model_write(a, d);
        oxq.push_back(x[2:1]);
        void'(oxq.pop_front());
        #1;
        if (w | r) checkOutput("rvalid", 32'(rvalid), 32'(r));
        if (r) checkOutput($sformatf("rdata@%0d", a), 32'(rdata), 32'(rexp));
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        applyStimulus(1'b0, 6'd0, 11'd0, 11'd0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [6:0] a);
        applyStimulus(1'b0, 6'd0, 11'd0, 11'd0, 1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic sample(input logic [10:0] ph, input logic [10:0] md);
        applyStimulus(1'b1, 6'd0, ph, md, 1'b0, 1'b0, 7'd0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 6'd0, 11'd0, 11'd0, 1'b0, 1'b0, 7'd0, 8'h00);
    endtask

    always @(negedge sCLK_XVXOSC) begin
        if (iRST_N) begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                checkOutput("out_valid", 32'(out_valid), 32'd1);
                checkOutput("osc_out", 32'(osc_out), 32'(sb[0].val));
                last_out = sb[0].val;
                void'(sb.pop_front());
            end else begin
                checkOutput("out_valid_idle", 32'(out_valid), 32'd0);
                checkOutput("osc_out_hold", 32'(osc_out), 32'(last_out));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iRST_N = 1'b0; adr = '0; wdata = '0; wr_en = 0; rd_en = 0; osc_sel = 0;
        xxxx = '0; in_valid = 0; phase_acc = '0; modulation = '0;
        model_reset();
        repeat (3) @(posedge sCLK_XVXOSC);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_osc_out", 32'(osc_out), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        @(negedge sCLK_XVXOSC);
        #1 iRST_N = 1'b1;

        // Register access, unmapped read and read-before-write.
        wr(7'd22, 8'h10);
        rd(7'd22);
        rd(7'd5);
        rd(7'd23);
        rd(7'd24);
        applyStimulus(1'b0, 6'd0, 11'd0, 11'd0, 1'b1, 1'b1, 7'd6, 8'h33);
        rd(7'd6);
        wr(7'd6, 8'h00);

        // Sine defaults.
        sample(11'd0, 11'd0);
        sample(11'd512, 11'd0);
        sample(11'd1536, 11'd0);
        idle(3);

        // Saw, including modulation wrap.
        wr(7'd7, 8'h01);
        sample(11'd0, 11'd0);
        sample(11'h7FF, 11'd0);
        sample(11'd100, 11'h7CE);
        idle(3);

        // Square with pulse-width edges.
        wr(7'd7, 8'h02);
        sample(11'd1023, 11'd0);
        sample(11'd1024, 11'd0);
        wr(7'd8, 8'h00);
        sample(11'd0, 11'd0);
        sample(11'd2047, 11'd0);
        wr(7'd8, 8'hFF);
        sample(11'd2039, 11'd0);
        sample(11'd2040, 11'd0);
        idle(3);

        // Offset wraps the phase silently.
        wr(7'd7, 8'h01);
        wr(7'd6, 8'h01);
        sample(11'h7FF, 11'd0);
        wr(7'd6, 8'h00);

        // Triangle corners.
        wr(7'd7, 8'h03);
        sample(11'd0, 11'd0);
        sample(11'd512, 11'd0);
        sample(11'd1023, 11'd0);
        sample(11'd1024, 11'd0);
        sample(11'd2047, 11'd0);
        idle(3);

        // Streaming frames with distinct oscillators and a mid-frame write.
        wr(7'd23, 8'h03);
        wr(7'd39, 8'h01);
        wr(7'd56, 8'h40);
        sample(11'd0, 11'd0);
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 64; s++) begin
                applyStimulus(1'b1, 6'(s), 11'($urandom_range(0, 2047)),
                              11'($urandom_range(0, 2047)),
                              (f == 0 && s == 20), 1'b0, 7'd7, 8'h00);
            end
        end
        for (int s = 0; s < 10; s++)
            applyStimulus(1'b1, 6'(s + 1), 11'($urandom_range(0, 2047)), 11'd0,
                          1'b0, 1'b0, 7'd0, 8'h00);

        // Asynchronous reset while samples are in flight.
        in_valid = 1'b0; wr_en = 1'b0; rd_en = 1'b0; osc_sel = 1'b0; xxxx = '0;
        iRST_N = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_osc_out", 32'(osc_out), 32'd0);
        model_reset();
        repeat (2) @(negedge sCLK_XVXOSC);
        #1 iRST_N = 1'b1;
        rd(7'd7);
        rd(7'd8);
        rd(7'd22);
        sample(11'd512, 11'd0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
